stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that shares one 128-bit outbound stream among `NUM_CH` inbound 128-bit streams on the StreamLoopback128 card image. It sits between the per-channel stream endpoints and the single loopback/return stream. It grants one channel at a time for a bounded burst, registers the selected beat with its source channel number, and keeps full valid/rdy backpressure on both sides.

## Interface
- `NUM_CH`, 4: number of inbound streams; 2..8.
- `DATA_W`, 128: stream data width.
- `CHW`, 2: channel index width; must equal ceil(log2(`NUM_CH`)).
- `BURST_MAX`, 16: maximum beats per grant; 1..255.
- `clk` in 1: stream clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_in_valid` in `NUM_CH`: per-channel beat valid.
- `s_in_rdy` out `NUM_CH`: per-channel ready.
- `s_in_data` in `NUM_CH`*`DATA_W`: channel k occupies bits [k*`DATA_W` +: `DATA_W`].
- `s_out_valid` out 1: output beat valid.
- `s_out_rdy` in 1: downstream ready.
- `s_out_data` out `DATA_W`: output beat.
- `s_out_chan` out `CHW`: source channel of the current output beat.
- `grant` out `NUM_CH`: one-hot current owner; all zero when idle.
- `beat_count` out `NUM_CH`*32: per-channel accepted-beat counters; present only with `STREAM_ARB_STATS_EN`.

## Operation
- Two states: IDLE and GRANT.
- IDLE: `grant`=0 and all `s_in_rdy`=0. If any `s_in_valid` is set, select the first set channel searching upward from `last`+1 with wrap-around. Register `grant`, load `burst_cnt`=0, and go to GRANT.
- GRANT (owner g):
  - `s_in_rdy[g]` = !`s_out_valid` || `s_out_rdy`. All other `s_in_rdy` are 0.
  - A beat is accepted when `s_in_valid[g]` && `s_in_rdy[g]`. On acceptance, the output register loads data and `s_out_chan`=g, `s_out_valid`=1, and `burst_cnt` increments.
  - Exit to IDLE with `last`=g when an accepted beat makes `burst_cnt` equal `BURST_MAX`.
  - Also exit to IDLE with `last`=g on any cycle where `s_in_valid[g]`=0 (owner went idle).
  - A cycle where `s_in_valid[g]`=1 but `s_in_rdy[g]`=0 (output stall) neither releases the grant nor counts a beat.
- Output register:
  - `s_out_valid` clears when `s_out_rdy`=1 and no new beat is accepted.
  - `s_out_data` and `s_out_chan` hold stable while `s_out_valid` && !`s_out_rdy`.
- Only valid beats are ever presented. No beat is duplicated or dropped, and per-channel beat order is preserved.
- Fairness: with all channels continuously valid, the grant order is 0,1,2,3,0,… and each grant lasts exactly `BURST_MAX` beats.
- `burst_cnt` is 8 bits. `BURST_MAX`=1 yields one beat per grant.

## Timing
- Reset (async assert, sync release): state=IDLE, `grant`=0, `s_in_rdy`=0, `s_out_valid`=0, `s_out_data`=0, `s_out_chan`=0, `last`=`NUM_CH`-1 (so channel 0 wins first), `beat_count`=0.
- Reset asserted mid-burst discards the in-flight output beat; nothing is replayed.
- Arbitration costs one dead cycle: a valid seen in IDLE gives `grant` and `s_in_rdy` on the next cycle.
- Input acceptance to `s_out_valid`: 1 cycle.
- Sustained throughput is one beat per cycle within a burst. Between bursts there is one idle cycle, plus one more when the release is caused by the owner dropping valid.
- The outbound handshake is registered only. `s_in_rdy` depends combinationally on `s_out_rdy`; this is the single combinational path.

## Configuration
- `STREAM_ARB_STATS_EN` defined:
  - `beat_count` is present.
  - Counter k increments on every accepted beat from channel k.
  - Counters wrap from 0xFFFFFFFF to 0 and are cleared only by reset.
- Undefined: the `beat_count` port and counters are removed. All other behaviour is identical.

## Test plan
- Single stream: ch1 sends 16 beats, values 0x1..0x10, `s_out_rdy`=1 → output shows the same 16 beats in order with `s_out_chan`=1, first output 2 cycles after the first valid; `grant` returns to 0 after ch1 drops valid.
- Full contention: all 4 channels continuously valid, `BURST_MAX`=4 → `s_out_chan` sequence is 0×4, 1×4, 2×4, 3×4, 0×4, with exactly one bubble between bursts.
- Backpressure: ch0 streaming, `s_out_rdy` low for 5 cycles mid-burst → `s_out_data` is held stable, `s_in_rdy[0]`=0 during the stall, no loss or duplication, and `burst_cnt` is unchanged across the stall.
- Early release: ch2 sends 3 beats then drops valid while ch3 is waiting → ch2 released after 3 beats; ch3 granted 2 cycles after ch2's last accepted beat.
- Reset mid-burst: assert `rst_n`=0 during beat 7 of a ch0 burst → all outputs reach reset values immediately; after release, ch0 wins first when all channels are valid.
- Stats (with `STREAM_ARB_STATS_EN`): send 0x30 beats on ch1 and 0x10 on ch3 → `beat_count` reads ch1=0x30, ch3=0x10, others 0.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Purpose  : Round-robin arbiter sharing one registered outbound stream among
//            NUM_CH inbound streams. A grant lasts at most BURST_MAX beats.
//            Optional per-channel accepted-beat counters are enabled by
//            defining STREAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 128,
  parameter int CHW       = 2,
  parameter int BURST_MAX = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        s_in_valid,
  output logic [NUM_CH-1:0]        s_in_rdy,
  input  logic [NUM_CH*DATA_W-1:0] s_in_data,
  output logic                     s_out_valid,
  input  logic                     s_out_rdy,
  output logic [DATA_W-1:0]        s_out_data,
  output logic [CHW-1:0]           s_out_chan,
  output logic [NUM_CH-1:0]        grant
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]     beat_count
`endif
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_CH-1:0]   r_grant;
  logic [NUM_CH-1:0]   w_grant_next;
  logic [CHW-1:0]      r_owner;
  logic [CHW-1:0]      w_owner_next;
  logic [CHW-1:0]      r_last;
  logic [CHW-1:0]      w_last_next;
  logic [CHW-1:0]      w_pick;
  logic [CHW-1:0]      w_cand;
  logic                w_pick_found;
  logic [7:0]          r_burst_cnt;
  logic [7:0]          w_burst_cnt_next;
  logic [7:0]          w_burst_inc;
  logic                w_out_free;
  logic                w_owner_valid;
  logic                w_accept;
  logic [DATA_W-1:0]   w_owner_data;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free    = !s_out_valid || s_out_rdy;
  assign w_owner_valid = s_in_valid[r_owner];
  assign w_accept      = (r_state == S_GRANT) && w_owner_valid && w_out_free;
  assign w_burst_inc   = r_burst_cnt + 8'd1;
  // Only the owner sees ready; this is the single combinational path from s_out_rdy.
  assign s_in_rdy      = r_grant & {NUM_CH{w_out_free}};
  assign grant         = r_grant;

  // Select the owner's data lane.
  always_comb begin
    w_owner_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_owner == CHW'(k)) begin
        w_owner_data = s_in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search: first valid channel upward from last+1, wrapping.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    w_cand       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = CHW'((int'(r_last) + i) % NUM_CH);
      if (!w_pick_found && s_in_valid[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick       = w_cand;
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, release on burst limit or owner idle.
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_owner_next     = r_owner;
    w_last_next      = r_last;
    w_burst_cnt_next = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_next     = S_GRANT;
          w_grant_next     = NUM_CH'(1) << w_pick;
          w_owner_next     = w_pick;
          w_burst_cnt_next = 8'd0;
        end
      end
      S_GRANT: begin
        if (!w_owner_valid || (w_accept && (w_burst_inc == 8'(BURST_MAX)))) begin
          w_state_next     = S_IDLE;
          w_grant_next     = '0;
          w_last_next      = r_owner;
          w_burst_cnt_next = w_burst_inc;
        end else if (w_accept) begin
          w_burst_cnt_next = w_burst_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  // Arbitration state registers; last starts at NUM_CH-1 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_last      <= CHW'(NUM_CH - 1);
      r_burst_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_owner     <= w_owner_next;
      r_last      <= w_last_next;
      r_burst_cnt <= w_burst_cnt_next;
    end
  end

  // Output beat register: load on acceptance, hold while stalled, clear when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out_valid <= 1'b0;
      s_out_data  <= '0;
      s_out_chan  <= '0;
    end else if (w_accept) begin
      s_out_valid <= 1'b1;
      s_out_data  <= w_owner_data;
      s_out_chan  <= r_owner;
    end else if (s_out_rdy) begin
      s_out_valid <= 1'b0;
    end
  end

`ifdef STREAM_ARB_STATS_EN
  logic [31:0] r_beat_cnt [NUM_CH];

  // Per-channel accepted-beat counters; wrap naturally, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_beat_cnt[k] <= 32'd0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_owner == CHW'(k)) begin
          r_beat_cnt[k] <= r_beat_cnt[k] + 32'd1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_beat_count
    assign beat_count[k*32 +: 32] = r_beat_cnt[k];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Purpose  : Self-checking bench for stream_rr_arbiter. Directed scenarios
//            plus randomized traffic checked by a per-channel scoreboard and
//            a rule-level arbitration model. Stats checks run when
//            STREAM_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 128;
  localparam int CHW       = 2;
  localparam int BURST_MAX = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        s_in_valid;
  logic [NUM_CH-1:0]        s_in_rdy;
  logic [NUM_CH*DATA_W-1:0] s_in_data;
  logic                     s_out_valid;
  logic                     s_out_rdy;
  logic [DATA_W-1:0]        s_out_data;
  logic [CHW-1:0]           s_out_chan;
  logic [NUM_CH-1:0]        grant;
`ifdef STREAM_ARB_STATS_EN
  logic [NUM_CH*32-1:0]     beat_count;
`endif

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .CHW      (CHW),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in_valid (s_in_valid),
    .s_in_rdy   (s_in_rdy),
    .s_in_data  (s_in_data),
    .s_out_valid(s_out_valid),
    .s_out_rdy  (s_out_rdy),
    .s_out_data (s_out_data),
    .s_out_chan (s_out_chan),
    .grant      (grant)
`ifdef STREAM_ARB_STATS_EN
    ,
    .beat_count (beat_count)
`endif
  );

  // Reference state: sources, expected outputs, and arbitration history.
  logic [DATA_W-1:0] src_q [NUM_CH][$];
  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  logic [7:0]        out_pat [$];
  int                rel_lens [$];
  int                acc_cnt [NUM_CH];

  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  int                seq_no   = 0;
  int                burst_len = 0;
  int                model_last = NUM_CH - 1;
  bit                vld_random = 1'b0;
  bit                rdy_random = 1'b0;
  bit                rdy_force_low = 1'b0;

  logic [NUM_CH-1:0] pend_acc   = '0;
  logic [NUM_CH-1:0] prev_grant = '0;
  logic [NUM_CH-1:0] prev_valid = '0;
  logic              prev_stall = 1'b0;
  logic              prev_owner_valid = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic [CHW-1:0]    prev_chan  = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec arbitration rule: first requester upward from last+1 with wrap.
  function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] v, input int last);
    for (int i = 1; i <= NUM_CH; i++) begin
      if (v[(last + i) % NUM_CH]) return NUM_CH'(1) << ((last + i) % NUM_CH);
    end
    return '0;
  endfunction

  function automatic bit drained();
    bit d = !s_out_valid;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic load(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      src_q[ch].push_back({$urandom, $urandom, $urandom, 8'(ch), 24'(seq_no)});
      seq_no++;
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      s_in_valid[c] = (src_q[c].size() != 0) && (!vld_random || ($urandom_range(0, 3) != 0));
      s_in_data[c*DATA_W +: DATA_W] = s_in_valid[c] ? src_q[c][0] : '0;
    end
    s_out_rdy = rdy_force_low ? 1'b0 : (rdy_random ? ($urandom_range(0, 2) != 0) : 1'b1);
  endtask

  task automatic observe();
    int c;
    check("grant_onehot0", 128'($onehot0(grant)), 128'(1));
    check("in_rdy", 128'(s_in_rdy), 128'(grant & {NUM_CH{(!s_out_valid) || s_out_rdy}}));
    if (prev_stall) begin
      check("hold_valid", 128'(s_out_valid), 128'(1));
      check("hold_data", s_out_data, prev_data);
      check("hold_chan", 128'(s_out_chan), 128'(prev_chan));
    end
    if (prev_grant == '0) begin
      check("arb_pick", 128'(grant), 128'(rr_pick(prev_valid, model_last)));
    end else if (grant != prev_grant) begin
      check("release_to_idle", 128'(grant), 128'(0));
      if (prev_owner_valid) check("burst_full", 128'(burst_len), 128'(BURST_MAX));
      else check("burst_bound", 128'(burst_len <= BURST_MAX), 128'(1));
      rel_lens.push_back(burst_len);
      for (int k = 0; k < NUM_CH; k++) if (prev_grant[k]) model_last = k;
      burst_len = 0;
    end
    if (s_out_valid && s_out_rdy) begin
      c = int'(s_out_chan);
      check("out_pending", 128'(exp_q[c].size() != 0), 128'(1));
      if (exp_q[c].size() != 0) begin
        check("out_data", s_out_data, exp_q[c][0]);
        void'(exp_q[c].pop_front());
      end
    end
    out_pat.push_back(s_out_valid ? 8'(s_out_chan) : 8'hFF);
    pend_acc         = s_in_valid & s_in_rdy;
    prev_stall       = s_out_valid && !s_out_rdy;
    prev_data        = s_out_data;
    prev_chan        = s_out_chan;
    prev_grant       = grant;
    prev_valid       = s_in_valid;
    prev_owner_valid = |(s_in_valid & grant);
  endtask

  // One cycle: retire beats accepted at the last edge, drive, settle, observe.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_acc[c] && src_q[c].size() != 0) begin
        exp_q[c].push_back(src_q[c][0]);
        void'(src_q[c].pop_front());
        acc_cnt[c]++;
        burst_len++;
      end
    end
    drive_inputs();
    #1;
    observe();
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n = 0;
    while (!drained() && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 128'(drained()), 128'(1));
  endtask

  task automatic clear_model();
    for (int c = 0; c < NUM_CH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
      acc_cnt[c] = 0;
    end
    pend_acc = '0; prev_grant = '0; prev_valid = '0; prev_stall = 1'b0;
    prev_owner_valid = 1'b0; burst_len = 0; model_last = NUM_CH - 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 128'(grant), 128'(0));
    check({tag, "_in_rdy"}, 128'(s_in_rdy), 128'(0));
    check({tag, "_out_valid"}, 128'(s_out_valid), 128'(0));
    check({tag, "_out_data"}, s_out_data, 128'(0));
    check({tag, "_out_chan"}, 128'(s_out_chan), 128'(0));
  endtask

  initial begin
    int s0, first, t, last2, start, f, n;
    logic [DATA_W-1:0] first_data;
    logic [7:0] exp_pat [$];

    rst_n = 1'b0; s_in_valid = '0; s_in_data = '0; s_out_rdy = 1'b1;
    clear_model();
    #1;
    check_reset_outputs("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();

`ifdef STREAM_ARB_STATS_EN
    // Stats: counts per channel from reset.
    load(1, 'h30); load(3, 'h10);
    run_until_drained("stats", 400);
    check("stats_ch0", 128'(beat_count[0*32 +: 32]), 128'(0));
    check("stats_ch1", 128'(beat_count[1*32 +: 32]), 128'('h30));
    check("stats_ch2", 128'(beat_count[2*32 +: 32]), 128'(0));
    check("stats_ch3", 128'(beat_count[3*32 +: 32]), 128'('h10));
`endif

    // Single stream: ch1 sends 0x1..0x10.
    for (int i = 1; i <= 16; i++) src_q[1].push_back(128'(i));
    step();
    s0 = cyc; first = -1; first_data = '0; n = 0;
    while (first < 0 && n < 20) begin
      if (s_out_valid) begin first = cyc; first_data = s_out_data; end
      else step();
      n++;
    end
    check("single_latency", 128'(first - s0), 128'(2));
    check("single_first_data", first_data, 128'(1));
    run_until_drained("single", 200);
    repeat (2) step();
    check("single_grant_idle", 128'(grant), 128'(0));

    // Full contention: expect BURST_MAX beats per owner, one bubble between.
    start = (model_last + 1) % NUM_CH;
    exp_pat.delete();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < BURST_MAX; k++) exp_pat.push_back(8'((start + b) % NUM_CH));
      exp_pat.push_back(8'hFF);
    end
    for (int c = 0; c < NUM_CH; c++) load(c, 20);
    out_pat.delete();
    repeat (60) step();
    f = 0;
    while (f < out_pat.size() && out_pat[f] == 8'hFF) f++;
    for (int i = 0; i < 5 * (BURST_MAX + 1) - 1; i++) begin
      if (f + i < out_pat.size()) check($sformatf("contention_%0d", i), 128'(out_pat[f + i]), 128'(exp_pat[i]));
      else check($sformatf("contention_%0d", i), 128'(8'hEE), 128'(exp_pat[i]));
    end
    run_until_drained("contention", 400);

    // Backpressure: stall the output for 5 cycles during a ch0 burst.
    rel_lens.delete();
    load(0, 12);
    n = 0;
    while (!s_out_valid && n < 20) begin step(); n++; end
    check("bp_first_out", 128'(s_out_valid), 128'(1));
    rdy_force_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_rdy0", 128'(s_in_rdy[0]), 128'(0));
      check("bp_grant_held", 128'(grant), 128'(1));
    end
    rdy_force_low = 1'b0;
    run_until_drained("bp", 200);
    check("bp_release_seen", 128'(rel_lens.size() != 0), 128'(1));
    if (rel_lens.size() != 0) check("bp_burst_len", 128'(rel_lens[0]), 128'(BURST_MAX));

    // Early release: ch2 sends 3 beats while ch3 waits.
    rel_lens.delete();
    load(2, 3); load(3, 4);
    last2 = -100; t = -1; n = 0;
    while (t < 0 && n < 40) begin
      step();
      if (pend_acc[2]) last2 = cyc;
      if (grant == 4'b1000) t = cyc;
      n++;
    end
    // Accept recorded one edge ahead; grant two edges after that accept.
    check("early_gap", 128'(t - last2), 128'(3));
    check("early_release_seen", 128'(rel_lens.size() != 0), 128'(1));
    if (rel_lens.size() != 0) check("early_len", 128'(rel_lens[0]), 128'(3));
    run_until_drained("early", 200);

    // Reset mid-burst, asserted between clock edges.
    for (int c = 0; c < NUM_CH; c++) load(c, 10);
    n = 0;
    while (!(burst_len >= 2 && grant != '0) && n < 50) begin step(); n++; end
    check("rst_mid_burst_reached", 128'(burst_len >= 2), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    clear_model();
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) load(c, 5);
    n = 0;
    while (grant == '0 && n < 20) begin step(); n++; end
    check("rst_first_grant", 128'(grant), 128'(1));
    run_until_drained("rst", 300);

    // Randomized traffic with random valid gaps and output backpressure.
    vld_random = 1'b1; rdy_random = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NUM_CH; c++) load(c, int'($urandom_range(0, 20)));
      run_until_drained($sformatf("random%0d", r), 3000);
    end
    vld_random = 1'b0; rdy_random = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
